cpu_controller: RTL and testbench



---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_controller_if.sv | 33 +++
 rtl/cpu_controller_instr_dec.sv | 23 ++
 rtl/cpu_controller.sv | 144 ++++++++++++++
 tb/tb_cpu_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller.
// Opcode/op field values, ALU operation codes and the FSM state enum.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG,
    S_WR_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_AND  = 2'b10;
  localparam logic [1:0] ALUOP_MVN  = 2'b11;

  function automatic logic [15:0] sx8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction-source handshake plus datapath control lines of the controller.
// master = instruction source / datapath side, slave = controller.
interface cpu_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        write;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] imm_out;

  modport master (
    output s, load, in,
    input  w, vsel, loada, loadb, loadc, loads, asel, bsel, write,
    input  readnum, writenum, shift, ALUop, imm_out
  );

  modport slave (
    input  s, load, in,
    output w, vsel, loada, loadb, loadc, loads, asel, bsel, write,
    output readnum, writenum, shift, ALUop, imm_out
  );
endinterface

// File: rtl/cpu_controller_instr_dec.sv
// Combinational field split of the 16-bit instruction register.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sx8(ir[7:0]);

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: holds the IR, sequences register reads, the ALU
// step and the register write, and returns to WAIT (w=1) when done.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  cpu_controller_if.slave bus
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [1:0]  sh;
  logic [15:0] sximm8;

  logic        w;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        write;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  alu_op;

  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8)
  );

  // IR only changes while idle, so fields stay stable for a whole instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && bus.load) ir <= bus.in;
    end
  end

  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    vsel      = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    write     = 1'b0;
    readnum   = '0;
    writenum  = '0;
    shift     = '0;
    alu_op    = ALUOP_ADD;

    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (bus.s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM)      state_nxt = S_WR_IMM;
        else if (opcode == OPC_MOV && op == OP_MOV_REG) state_nxt = S_GET_B;
        else if (opcode == OPC_ALU)                     state_nxt = S_GET_A;
        else                                            state_nxt = S_WAIT;
      end
      S_GET_A: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = S_GET_B;
      end
      S_GET_B: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        // MOV reg passes the shifted Rm through as 0 + B.
        if (opcode == OPC_MOV) begin
          asel      = 1'b1;
          alu_op    = ALUOP_ADD;
          loadc     = 1'b1;
          state_nxt = S_WR_REG;
        end else if (op == OP_CMP) begin
          alu_op    = op;
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          alu_op    = op;
          loadc     = 1'b1;
          state_nxt = S_WR_REG;
        end
      end
      S_WR_REG: begin
        writenum  = rd;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WR_IMM: begin
        writenum  = rn;
        vsel      = 1'b1;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign bus.w        = w;
  assign bus.vsel     = vsel;
  assign bus.loada    = loada;
  assign bus.loadb    = loadb;
  assign bus.loadc    = loadc;
  assign bus.loads    = loads;
  assign bus.asel     = asel;
  assign bus.bsel     = bsel;
  assign bus.write    = write;
  assign bus.readnum  = readnum;
  assign bus.writenum = writenum;
  assign bus.shift    = shift;
  assign bus.ALUop    = alu_op;
  assign bus.imm_out  = sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a per-instruction
// expected output trace built from the instruction semantics.
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        write;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] imm;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [15:0] cur_ir;
  vec_t exp_q[$];

  cpu_controller_if bus();

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t obs();
    vec_t v;
    v.w = bus.w;         v.vsel = bus.vsel;
    v.loada = bus.loada; v.loadb = bus.loadb;
    v.loadc = bus.loadc; v.loads = bus.loads;
    v.asel = bus.asel;   v.bsel = bus.bsel;
    v.write = bus.write;
    v.readnum = bus.readnum; v.writenum = bus.writenum;
    v.shift = bus.shift; v.aluop = bus.ALUop;
    v.imm = bus.imm_out;
    return v;
  endfunction

  function automatic vec_t blank(input logic [15:0] ir);
    vec_t v;
    v = '0;
    v.imm = {{8{ir[7]}}, ir[7:0]};
    return v;
  endfunction

  function automatic vec_t idle(input logic [15:0] ir);
    vec_t v;
    v = blank(ir);
    v.w = 1'b1;
    return v;
  endfunction

  // Busy-cycle outputs implied by the instruction, one entry per cycle.
  function automatic void build(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] op;
    vec_t v;
    opc = ir[15:13];
    op  = ir[12:11];
    exp_q.delete();
    exp_q.push_back(blank(ir));
    if (opc == 3'b110 && op == 2'b10) begin
      v = blank(ir); v.writenum = ir[10:8]; v.vsel = 1'b1; v.write = 1'b1;
      exp_q.push_back(v);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      if (opc == 3'b101) begin
        v = blank(ir); v.readnum = ir[10:8]; v.loada = 1'b1;
        exp_q.push_back(v);
      end
      v = blank(ir); v.readnum = ir[2:0]; v.loadb = 1'b1;
      exp_q.push_back(v);
      v = blank(ir); v.shift = ir[4:3];
      if (opc == 3'b110) begin
        v.asel = 1'b1; v.aluop = 2'b00; v.loadc = 1'b1;
      end else begin
        v.aluop = op;
        if (op == 2'b01) v.loads = 1'b1;
        else             v.loadc = 1'b1;
      end
      exp_q.push_back(v);
      if (!(opc == 3'b101 && op == 2'b01)) begin
        v = blank(ir); v.writenum = ir[7:5]; v.write = 1'b1;
        exp_q.push_back(v);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at a sample point while the DUT sits in WAIT.
  task automatic run_instr(input logic [15:0] ir, input string name);
    int busy;
    chk({name, " idle_before"}, obs(), idle(cur_ir));
    bus.in = ir; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    cur_ir = ir;
    build(ir);
    busy = 0;
    foreach (exp_q[i]) begin
      chk($sformatf("%s cyc%0d", name, i), obs(), exp_q[i]);
      if (bus.w === 1'b0) busy++;
      bus.load = 1'($urandom);
      bus.s    = 1'($urandom);
      bus.in   = 16'($urandom);
      tick();
    end
    bus.load = 1'b0; bus.s = 1'b0;
    chk({name, " busy_cycles"}, 35'(busy), 35'(exp_q.size()));
    chk({name, " idle_after"}, obs(), idle(cur_ir));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:13] = 3'b101;
      3: if (r[15:13] == 3'b101) r[15:13] = 3'b011;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    checks = 0; errors = 0;
    cur_ir = 16'h0000;
    reset_n = 1'b0; bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
    tick();
    tick();
    chk("reset_state", obs(), idle(16'h0000));
    reset_n = 1'b1;
    bus.in = 16'hFFFF;
    tick();
    chk("post_reset_idle", obs(), idle(16'h0000));

    run_instr(16'hD207, "mov_r2_7");
    run_instr(16'hD1FD, "mov_r1_m3");
    run_instr(16'hA168, "add_lsl");
    run_instr(16'hA902, "cmp");
    run_instr(16'h0000, "unsupported");
    run_instr(16'hC06A, "mov_reg");
    run_instr(16'hB0E1, "and");
    run_instr(16'hB8E1, "mvn");
    run_instr(16'hC8FF, "mov_op01");

    // Reset in GET_B of an ADD aborts without a write.
    bus.in = 16'hA168; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    build(16'hA168);
    chk("rst_add decode", obs(), exp_q[0]);
    tick();
    chk("rst_add get_a", obs(), exp_q[1]);
    tick();
    chk("rst_add get_b", obs(), exp_q[2]);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cur_ir = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_abort idle%0d", i), obs(), idle(16'h0000));
      tick();
    end

    // s held high re-enters DECODE straight after one WAIT cycle.
    bus.in = 16'hD305; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0;
    cur_ir = 16'hD305;
    build(16'hD305);
    foreach (exp_q[i]) begin
      chk($sformatf("hold_s cyc%0d", i), obs(), exp_q[i]);
      tick();
    end
    chk("hold_s wait", obs(), idle(cur_ir));
    tick();
    bus.s = 1'b0;
    foreach (exp_q[i]) begin
      chk($sformatf("hold_s again%0d", i), obs(), exp_q[i]);
      tick();
    end
    chk("hold_s done", obs(), idle(cur_ir));

    for (int n = 0; n < 60; n++) begin
      run_instr(rand_instr(), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
